pc_next_sequencer: RTL and testbench
====================================

Name: pc_next_sequencer

Overview:
- Parametrised successor to the fixed 4-input PC-source multiplexer. It selects the next PC from NUM_SRC candidate addresses, registers it, and adds halt, resume, stall, misalignment trapping and redirect counting.
- Sits in the fetch stage. It drives the instruction-memory address and takes candidates from the adder, branch and jump logic.
- The halt function moves out of the mux-feedback path into an explicit state machine.

Parameters:
- N, 32, PC and candidate address width.
- NUM_SRC, 4, number of candidate sources, 2..8. Source 0 is the sequential PC+4 path by convention.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded when a misaligned target is selected.
- ALIGN_BITS, 2, number of low address bits that must be zero for a legal target.
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- src_addr  in  NUM_SRC*N  flattened candidates; source k occupies bits [k*N +: N].
- src_sel  in  $clog2(NUM_SRC)  source index for the next PC.
- stall  in  1  hold the PC this cycle.
- halt_req  in  1  enter the halted state.
- resume  in  1  leave the halted state.
- pc  out  N  current PC, registered.
- pc_valid  out  1  high when pc addresses a fetchable instruction.
- halted  out  1  high while in HALTED.
- misalign_trap  out  1  one-cycle pulse when a misaligned target is redirected to TRAP_PC.
- redirect_cnt  out  CNT_W  count of non-sequential PC loads, saturating.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset values, applied asynchronously while rst_n=0:
  - pc=RESET_PC
  - state=BOOT
  - pc_valid=0, halted=0, misalign_trap=0, redirect_cnt=0
- States: BOOT, RUN, HALTED. All outputs are registered; pc_valid and halted are decoded from registered state (pc_valid=1 in RUN and HALTED).
- BOOT: lasts exactly one cycle after reset release, then unconditionally goes to RUN. pc holds RESET_PC and inputs are ignored. First fetch is of RESET_PC with pc_valid=1.
- Candidate selection: the selected candidate is src_addr[src_sel]. If src_sel >= NUM_SRC (non-power-of-two NUM_SRC), source 0 is used instead.
- RUN, in priority order each cycle:
  1. halt_req=1: go to HALTED; pc holds. halt_req overrides stall and any selection.
  2. stall=1: pc holds, state stays RUN, counter unchanged.
  3. Otherwise, candidate low ALIGN_BITS nonzero: pc<=TRAP_PC and misalign_trap=1 next cycle. Counter unchanged; this applies even when source 0 is the misaligned one.
  4. Otherwise pc<=candidate. If the effective source index is not 0, redirect_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- HALTED:
  - pc holds its value and halted=1.
  - stall, src_sel and src_addr are ignored.
  - resume=1 with halt_req=0: go to RUN next cycle, pc unchanged. The first post-resume cycle performs a normal RUN update.
  - resume=1 with halt_req=1: stay HALTED.
- Other cases:
  - resume outside HALTED is ignored.
  - halt_req held continuously keeps the block in HALTED.
- misalign_trap: high for exactly the one cycle after the trapping edge. Back-to-back misaligned selections give back-to-back pulses.
- Latency: the chosen next PC appears on pc one clock after the edge at which its inputs are sampled. There is no combinational path from inputs to outputs.
- Reset mid-operation: asserting rst_n=0 in any state immediately forces the reset values above, including clearing redirect_cnt. Resuming requires the BOOT cycle again.
- Arithmetic: no adders inside the block except the counter increment. PC+4 is supplied externally on source 0.

Test Plan:
- Reset/boot: rst_n low 3 cycles then high, src0=0x4, sel=0 -> pc=0x0 with pc_valid=0 for 1 cycle; then pc=0x0, pc_valid=1; next edge pc=0x4.
- Selection and count: NUM_SRC=4, RUN, src2=0x200, sel=2 -> pc=0x200 next cycle, redirect_cnt=1. Then sel=0 with src0=0x204 -> pc=0x204, cnt still 1. Then sel=3 -> cnt=2.
- Stall vs halt: stall=1 for 2 cycles at pc=0x40 -> pc stays 0x40. Then halt_req=1 and stall=1 together -> halted=1, pc=0x40. Then resume=1 -> halted=0 next cycle, pc=0x40, then advances to src0.
- Misalignment: sel=1, src1=0x102 -> pc=0x100 (TRAP_PC), misalign_trap=1 for exactly one cycle, cnt unchanged.
- Saturation and range: CNT_W=2, five non-zero-source loads -> redirect_cnt sticks at 3. NUM_SRC=3 with sel=3 -> src0 loaded, cnt unchanged.
- Async reset mid-HALTED: rst_n pulsed low between clock edges -> pc=RESET_PC and halted=0 immediately without a clock; BOOT cycle repeats.

Source files
------------

// File: rtl/pc_next_sequencer.sv
// Fetch-stage next-PC sequencer: picks one of NUM_SRC candidates, registers it,
// and layers boot/halt/resume control, stall, misalignment trapping and redirect counting.
module pc_next_sequencer #(
  parameter int unsigned     N          = 32,
  parameter int unsigned     NUM_SRC    = 4,
  parameter logic [N-1:0]    RESET_PC   = 32'h0000_0000,
  parameter logic [N-1:0]    TRAP_PC    = 32'h0000_0100,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*N-1:0]       src_addr,
  input  logic [$clog2(NUM_SRC)-1:0] src_sel,
  input  logic                       stall,
  input  logic                       halt_req,
  input  logic                       resume,
  output logic [N-1:0]               pc,
  output logic                       pc_valid,
  output logic                       halted,
  output logic                       misalign_trap,
  output logic [CNT_W-1:0]           redirect_cnt
);

  localparam int unsigned SEL_W = $clog2(NUM_SRC);
  localparam logic [N-1:0] ALIGN_MASK = N'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       pc_q, pc_d;
  logic               trap_q, trap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N-1:0]       cand;
  logic               cand_nonseq;
  logic               cand_misaligned;

  // Out-of-range selects fall back to the sequential source 0.
  always_comb begin
    cand        = src_addr[N-1:0];
    cand_nonseq = 1'b0;
    for (int k = 1; k < int'(NUM_SRC); k++) begin
      if (src_sel == SEL_W'(k)) begin
        cand        = src_addr[k*N +: N];
        cand_nonseq = 1'b1;
      end
    end
    cand_misaligned = |(cand & ALIGN_MASK);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    trap_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (cand_misaligned) begin
          pc_d   = TRAP_PC;
          trap_d = 1'b1;
        end else begin
          pc_d = cand;
          if (cand_nonseq && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HALTED: begin
        if (resume && !halt_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      trap_q  <= trap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = (state_q == RUN) || (state_q == HALTED);
  assign halted        = (state_q == HALTED);
  assign misalign_trap = trap_q;
  assign redirect_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_next_sequencer.sv
// Directed bench for pc_next_sequencer: a default 4-source instance driven from a
// vector table, and a 3-source / 2-bit-counter instance for range and saturation.
module tb_pc_next_sequencer;

  logic clk;
  logic rst_n;
  logic [4*32-1:0] a_src;
  logic [1:0]      a_sel;
  logic            a_stall, a_halt, a_resume;
  logic [31:0]     a_pc;
  logic            a_valid, a_halted, a_trap;
  logic [15:0]     a_cnt;

  logic            b_rst_n;
  logic [3*32-1:0] b_src;
  logic [1:0]      b_sel;
  logic [31:0]     b_pc;
  logic            b_valid, b_halted, b_trap;
  logic [1:0]      b_cnt;

  int n_total = 0;
  int n_pass  = 0;

  pc_next_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .src_addr(a_src), .src_sel(a_sel),
    .stall(a_stall), .halt_req(a_halt), .resume(a_resume),
    .pc(a_pc), .pc_valid(a_valid), .halted(a_halted),
    .misalign_trap(a_trap), .redirect_cnt(a_cnt)
  );

  pc_next_sequencer #(.NUM_SRC(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(b_rst_n), .src_addr(b_src), .src_sel(b_sel),
    .stall(1'b0), .halt_req(1'b0), .resume(1'b0),
    .pc(b_pc), .pc_valid(b_valid), .halted(b_halted),
    .misalign_trap(b_trap), .redirect_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic        stall;
    logic        halt;
    logic        resume;
    logic [31:0] exp_pc;
    logic        exp_halted;
    logic        exp_trap;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] sel, input logic [31:0] addr,
                         input logic st, input logic hr, input logic rs);
    for (int k = 0; k < 4; k++) a_src[k*32 +: 32] = 32'hDEAD_0000 + 32'(k * 16);
    a_src[int'(sel)*32 +: 32] = addr;
    a_sel    = sel;
    a_stall  = st;
    a_halt   = hr;
    a_resume = rs;
  endtask

  task automatic drive_b(input logic [1:0] sel, input logic [31:0] s0,
                         input logic [31:0] s1, input logic [31:0] s2);
    b_src = {s2, s1, s0};
    b_sel = sel;
  endtask

  initial begin
    //            sel    addr          st   hr   rs   exp_pc        hlt  trp  cnt
    vt[0]  = '{2'd0, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
    vt[1]  = '{2'd0, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 16'd0};
    vt[2]  = '{2'd2, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 16'd1};
    vt[3]  = '{2'd0, 32'h0000_0204, 1'b0, 1'b0, 1'b0, 32'h0000_0204, 1'b0, 1'b0, 16'd1};
    vt[4]  = '{2'd3, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 16'd2};
    vt[5]  = '{2'd2, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 16'd2};
    vt[6]  = '{2'd0, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 16'd2};
    vt[7]  = '{2'd2, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 16'd2};
    vt[8]  = '{2'd2, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 16'd2};
    vt[9]  = '{2'd1, 32'h0000_0300, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 16'd2};
    vt[10] = '{2'd2, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 16'd2};
    vt[11] = '{2'd0, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 1'b0, 1'b0, 16'd2};
    vt[12] = '{2'd1, 32'h0000_0102, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 16'd2};
    vt[13] = '{2'd1, 32'h0000_0106, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 16'd2};
    vt[14] = '{2'd0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 16'd2};
    vt[15] = '{2'd0, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 1'b0, 1'b0, 16'd2};
    vt[16] = '{2'd0, 32'h0000_0108, 1'b0, 1'b0, 1'b1, 32'h0000_0108, 1'b0, 1'b0, 16'd2};
    vt[17] = '{2'd2, 32'h0000_0300, 1'b0, 1'b1, 1'b0, 32'h0000_0108, 1'b1, 1'b0, 16'd2};

    rst_n   = 1'b0;
    b_rst_n = 1'b0;
    drive_a(2'd0, 32'h4, 1'b0, 1'b0, 1'b0);
    drive_b(2'd0, 32'h0, 32'h0, 32'h0);
    repeat (3) tick();
    chk("reset_pc",     64'(a_pc),     64'h0);
    chk("reset_valid",  64'(a_valid),  64'd0);
    chk("reset_halted", 64'(a_halted), 64'd0);
    chk("reset_trap",   64'(a_trap),   64'd0);
    chk("reset_cnt",    64'(a_cnt),    64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive_a(vt[i].sel, vt[i].addr, vt[i].stall, vt[i].halt, vt[i].resume);
      tick();
      chk($sformatf("vec%0d_pc", i),     64'(a_pc),     64'(vt[i].exp_pc));
      chk($sformatf("vec%0d_valid", i),  64'(a_valid),  64'd1);
      chk($sformatf("vec%0d_halted", i), 64'(a_halted), 64'(vt[i].exp_halted));
      chk($sformatf("vec%0d_trap", i),   64'(a_trap),   64'(vt[i].exp_trap));
      chk($sformatf("vec%0d_cnt", i),    64'(a_cnt),    64'(vt[i].exp_cnt));
    end

    // Asynchronous reset pulse while HALTED, entirely between clock edges.
    drive_a(2'd0, 32'h10, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc",     64'(a_pc),     64'h0);
    chk("async_halted", 64'(a_halted), 64'd0);
    chk("async_valid",  64'(a_valid),  64'd0);
    chk("async_cnt",    64'(a_cnt),    64'd0);
    rst_n = 1'b1;
    tick();
    chk("reboot_pc",    64'(a_pc),    64'h0);
    chk("reboot_valid", 64'(a_valid), 64'd1);
    tick();
    chk("reboot_adv_pc", 64'(a_pc), 64'h10);

    // Three-source instance: out-of-range select, then counter saturation.
    b_rst_n = 1'b1;
    drive_b(2'd3, 32'h500, 32'h600, 32'h700);
    tick();
    chk("b_boot_pc",    64'(b_pc),    64'h0);
    chk("b_boot_valid", 64'(b_valid), 64'd1);
    tick();
    chk("b_range_pc",  64'(b_pc),  64'h500);
    chk("b_range_cnt", 64'(b_cnt), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive_b(2'(1 + (i % 2)), 32'h500, 32'h1000 + 32'(i * 32), 32'h2000 + 32'(i * 32));
      tick();
      chk($sformatf("b_sat%0d_pc", i), 64'(b_pc),
          (i % 2 == 0) ? 64'(32'h1000 + 32'(i * 32)) : 64'(32'h2000 + 32'(i * 32)));
      chk($sformatf("b_sat%0d_cnt", i), 64'(b_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    chk("b_sat_trap", 64'(b_trap), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
